// File: rtl/pe.sv
// pe: 8-input priority encoder with registered 3-bit index and valid flag.
// D7 has the highest priority and D0 the lowest. The encode is computed
// combinationally from the request lines and captured on every rising edge
// of clk. rst clears all outputs immediately, without waiting for an edge.
module pe (
    input  logic clk,
    input  logic rst,
    input  logic D7,
    input  logic D6,
    input  logic D5,
    input  logic D4,
    input  logic D3,
    input  logic D2,
    input  logic D1,
    input  logic D0,
    output logic A2,
    output logic A1,
    output logic A0,
    output logic V
);

    // Index of the highest-numbered set bit.
    // An all-zero vector returns 3'b000, so the caller must use the valid
    // flag to tell "no request" apart from "D0 only".
    function automatic logic [2:0] prio_encode(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'b000;
        // Scan upward so that the highest set bit is the last one written.
        for (int i = 0; i < 8; i++) begin
            if (req[i] == 1'b1) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [7:0] req_s;
    logic [2:0] idx_s;
    logic       valid_s;
    logic [2:0] idx_r;
    logic       valid_r;

    assign req_s = {D7, D6, D5, D4, D3, D2, D1, D0};

    // Next-state encode of the current request lines.
    always_comb begin
        idx_s   = 3'b000;
        valid_s = 1'b0;
        case (req_s == 8'h00)
            1'b1: begin
                idx_s   = 3'b000;
                valid_s = 1'b0;
            end
            1'b0: begin
                idx_s   = prio_encode(req_s);
                valid_s = 1'b1;
            end
            default: begin
                idx_s   = 3'b000;
                valid_s = 1'b0;
            end
        endcase
    end

    // Output register: cleared asynchronously by rst, otherwise loaded every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= 3'b000;
            valid_r <= 1'b0;
        end else begin
            idx_r   <= idx_s;
            valid_r <= valid_s;
        end
    end

    assign A2 = idx_r[2];
    assign A1 = idx_r[1];
    assign A0 = idx_r[0];
    assign V  = valid_r;

endmodule

// File: tb/tb_pe.sv
// tb_pe: directed self-checking bench for the pe priority encoder.
// Observed value is packed as {A2,A1,A0,V}.
module tb_pe;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       A2, A1, A0, V;

    int checks   = 0;
    int failures = 0;

    pe dut (
        .clk(clk),
        .rst(rst),
        .D7(d[7]),
        .D6(d[6]),
        .D5(d[5]),
        .D4(d[4]),
        .D3(d[3]),
        .D2(d[2]),
        .D1(d[1]),
        .D0(d[0]),
        .A2(A2),
        .A1(A1),
        .A0(A0),
        .V(V)
    );

    // 10-unit clock, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the current outputs against an expected {A2,A1,A0,V}.
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {A2, A1, A0, V};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a request vector mid-cycle, then check just after the next rising edge.
    task automatic step(input logic [7:0] din, input logic [3:0] exp, input string tag);
        @(negedge clk);
        d = din;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with all requests high: outputs clear immediately.
        rst = 1'b1;
        d   = 8'hFF;
        #1;
        check("reset_immediate", 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_edges", 4'b0000);

        // Release reset: the first edge captures the encode of 11111111.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", 4'b0000);
        @(posedge clk);
        #1;
        check("after_reset_ff", 4'b1111);

        // All-zero input.
        step(8'h00, 4'b0000, "all_zero");

        // Single-hot sweep.
        step(8'h80, 4'b1111, "hot_d7");
        step(8'h40, 4'b1101, "hot_d6");
        step(8'h20, 4'b1011, "hot_d5");
        step(8'h10, 4'b1001, "hot_d4");
        step(8'h08, 4'b0111, "hot_d3");
        step(8'h04, 4'b0101, "hot_d2");
        step(8'h02, 4'b0011, "hot_d1");
        step(8'h01, 4'b0001, "hot_d0");

        // Multi-request priority.
        step(8'hC8, 4'b1111, "multi_c8");
        step(8'h27, 4'b1011, "multi_27");

        // Latency and hold: changes between edges do not reach the outputs.
        @(negedge clk);
        d = 8'h01;
        #2;
        d = 8'h80;
        #1;
        check("hold_between_edges", 4'b1011);
        d = 8'h04;
        @(posedge clk);
        #1;
        check("edge_value_used", 4'b0101);
        d = 8'hFF;
        #2;
        check("hold_after_edge", 4'b0101);
        d = 8'h00;
        @(posedge clk);
        #1;
        check("edge_zero", 4'b0000);

        // Async reset mid-stream while A=101.
        step(8'h20, 4'b1011, "pre_reset_a101");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", 4'b0000);
        @(posedge clk);
        #1;
        check("async_reset_hold", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        d   = 8'h02;
        #1;
        check("release_wait_edge", 4'b0000);
        @(posedge clk);
        #1;
        check("resume_d1", 4'b0011);
        step(8'h60, 4'b1101, "resume_d6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- 8-input to 3-bit priority encoder with registered outputs.
- Reports the index of the highest-numbered asserted request line (D7 highest priority, D0 lowest), plus a valid flag.
- Used wherever one of eight request lines must be reduced to a binary index, e.g. interrupt or request arbitration front ends.
- Single clock domain; asynchronous active-high reset.

Parameters:
None. The width is fixed at 8 inputs and 3 index bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- D7  input  1  request line 7 (highest priority)
- D6  input  1  request line 6
- D5  input  1  request line 5
- D4  input  1  request line 4
- D3  input  1  request line 3
- D2  input  1  request line 2
- D1  input  1  request line 1
- D0  input  1  request line 0 (lowest priority)
- A2  output  1  encoded index, MSB
- A1  output  1  encoded index, middle bit
- A0  output  1  encoded index, LSB
- V  output  1  valid: at least one request line was high

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst=1: A2=A1=A0=0 and V=0 immediately, without waiting for a clock edge.
  - After rst deasserts, the first rising clk edge captures the encode of the current inputs.
- Encoding function (combinational, computed from D7..D0):
  - {A2,A1,A0} = index of the highest i with Di=1. The lower-priority lines are don't-care.
  - D7=1 -> 111; else D6=1 -> 110; else D5=1 -> 101; else D4=1 -> 100.
  - Else D3=1 -> 011; else D2=1 -> 010; else D1=1 -> 001; else D0=1 -> 000.
  - All inputs 0 -> {A2,A1,A0}=000 and V=0. V is the only way to tell this case apart from "D0 only".
  - V = OR of D7..D0.
- Registering:
  - A2, A1, A0 and V update only on the rising clk edge when rst=0.
  - Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
  - Outputs hold between edges regardless of input changes.
- No enable, no handshake. Every edge samples and encodes.
- Inputs are synchronous to clk. If they change between edges, only the value present at the edge matters.
- Reset asserted mid-operation: outputs clear at once and stay cleared until the first edge after deassertion. No pipeline state survives reset.
- Simultaneous multiple requests: only the highest index is reported. No error or conflict flag.

Test Plan:
- Reset check:
  - Assert rst with D7..D0=11111111 -> A=000, V=0 immediately, and they stay cleared across clock edges.
  - Deassert rst -> A=111, V=1 after the next edge.
- All-zero input:
  - D7..D0=00000000 -> A=000, V=0 one cycle later.
- Single-hot sweep:
  - Drive D7 only, then D6, D5, D4, D3, D2, D1, D0, one per cycle.
  - Outputs, each one cycle behind its input: A=111,110,101,100,011,010,001,000 with V=1 throughout.
- Multi-request priority:
  - D7,D6,D3=1 (11001000) -> A=111, V=1.
  - D5,D2,D1,D0=1 (00100111) -> A=101, V=1.
- Latency and hold:
  - Toggle inputs between clock edges -> outputs change only at rising edges and reflect the value present at that edge.
- Async reset mid-stream:
  - Assert rst between edges while A=101 -> outputs go to A=000, V=0 without a clock edge.
  - Release rst -> normal encoding resumes on the next edge.
